// File: rtl/pll_lock_monitor.sv
// PLL lock monitor: measures the signed ref-to-gen edge skew in fpga_clk_i ticks and
// tracks lock with a small IDLE/ACQUIRE/LOCKED/LOST state machine.
module pll_lock_monitor #(
  parameter int unsigned ERR_WIDTH    = 8,
  parameter int unsigned LOCK_TOL     = 2,
  parameter int unsigned LOCK_COUNT   = 16,
  parameter int unsigned UNLOCK_COUNT = 4,
  parameter int unsigned TIMEOUT      = 1023
) (
  input  logic                 fpga_clk_i,
  input  logic                 rst_pbn_i,
  input  logic                 enable_i,
  input  logic                 ref_clk_i,
  input  logic                 gen_clk_i,
  output logic [ERR_WIDTH-1:0] error_o,
  output logic                 error_valid_o,
  output logic                 locked_o,
  output logic                 lost_o,
  output logic [1:0]           state_o
);

  localparam int unsigned AgeW   = $clog2(TIMEOUT + 1);
  localparam int unsigned RunMax = (LOCK_COUNT > UNLOCK_COUNT) ? LOCK_COUNT : UNLOCK_COUNT;
  localparam int unsigned RunW   = $clog2(RunMax + 1);
  localparam logic [ERR_WIDTH-1:0] CntMax = {1'b0, {(ERR_WIDTH-1){1'b1}}};
  localparam logic [ERR_WIDTH-1:0] CntMin = {1'b1, {(ERR_WIDTH-2){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StAcquire = 2'd1,
    StLocked  = 2'd2,
    StLost    = 2'd3
  } state_e;

  logic [2:0]           r_ref_sync, r_gen_sync;
  logic                 r_open, r_dir_ref;
  logic [ERR_WIDTH-1:0] r_cnt, r_err;
  logic [AgeW-1:0]      r_age;
  logic                 r_valid;
  logic [RunW-1:0]      r_in_run, r_out_run;
  state_e               r_state;

  logic                 w_ref_pulse, w_gen_pulse, w_active, w_close, w_repeat;
  logic                 w_open_d, w_dir_d, w_pub, w_timeout, w_in_tol;
  logic [ERR_WIDTH-1:0] w_cnt_d, w_cnt_step, w_pub_val, w_abs;
  logic [AgeW-1:0]      w_age_d;
  logic [RunW-1:0]      w_in_run_d, w_out_run_d;
  state_e               w_state_d;

  // Bit 2 of each shift register is the edge-detect flop behind the 2-flop synchronizer.
  assign w_ref_pulse = r_ref_sync[1] & ~r_ref_sync[2];
  assign w_gen_pulse = r_gen_sync[1] & ~r_gen_sync[2];
  assign w_active    = enable_i && (r_state != StIdle);
  assign w_close     = r_dir_ref ? w_gen_pulse : w_ref_pulse;
  assign w_repeat    = r_dir_ref ? w_ref_pulse : w_gen_pulse;

  always_comb begin
    w_cnt_step = r_cnt;
    if (r_dir_ref) begin
      if (r_cnt != CntMax) w_cnt_step = r_cnt + ERR_WIDTH'(1);
    end else begin
      if (r_cnt != CntMin) w_cnt_step = r_cnt - ERR_WIDTH'(1);
    end
  end

  // Window tracking; the closing cycle counts as one tick of skew.
  always_comb begin
    w_open_d  = r_open;
    w_dir_d   = r_dir_ref;
    w_cnt_d   = r_cnt;
    w_age_d   = r_age;
    w_pub     = 1'b0;
    w_pub_val = '0;
    w_timeout = 1'b0;
    if (!w_active) begin
      w_open_d = 1'b0;
      w_cnt_d  = '0;
      w_age_d  = '0;
    end else if (r_open) begin
      if (w_close) begin
        w_pub     = 1'b1;
        w_pub_val = w_cnt_step;
        w_open_d  = 1'b0;
        w_cnt_d   = '0;
        w_age_d   = '0;
      end else if (w_repeat) begin
        w_cnt_d = '0;
        w_age_d = '0;
      end else if (r_age == AgeW'(TIMEOUT)) begin
        w_timeout = 1'b1;
        w_open_d  = 1'b0;
        w_cnt_d   = '0;
        w_age_d   = '0;
      end else begin
        w_cnt_d = w_cnt_step;
        w_age_d = r_age + AgeW'(1);
      end
    end else if (w_ref_pulse && w_gen_pulse) begin
      w_pub = 1'b1;
    end else if (w_ref_pulse || w_gen_pulse) begin
      w_open_d = 1'b1;
      w_dir_d  = w_ref_pulse;
      w_cnt_d  = '0;
      w_age_d  = '0;
    end
  end

  assign w_abs    = w_pub_val[ERR_WIDTH-1] ? (~w_pub_val + ERR_WIDTH'(1)) : w_pub_val;
  assign w_in_tol = (w_abs <= ERR_WIDTH'(LOCK_TOL));

  always_comb begin
    w_state_d   = r_state;
    w_in_run_d  = r_in_run;
    w_out_run_d = r_out_run;
    if (w_pub) begin
      if (w_in_tol) begin
        w_out_run_d = '0;
        if (r_in_run != RunW'(LOCK_COUNT)) w_in_run_d = r_in_run + RunW'(1);
      end else begin
        w_in_run_d = '0;
        if (r_out_run != RunW'(UNLOCK_COUNT)) w_out_run_d = r_out_run + RunW'(1);
      end
    end
    unique case (r_state)
      StIdle:    if (enable_i) w_state_d = StAcquire;
      StAcquire: if (w_pub && w_in_tol && w_in_run_d == RunW'(LOCK_COUNT)) w_state_d = StLocked;
      StLocked:  if (w_pub && !w_in_tol && w_out_run_d == RunW'(UNLOCK_COUNT)) begin
                   w_state_d = StAcquire;
                 end
      StLost:    if (w_pub) w_state_d = StAcquire;
      default:   w_state_d = StIdle;
    endcase
    if (w_timeout) w_state_d = StLost;
    if (!enable_i) w_state_d = StIdle;
    if (w_state_d != r_state && w_state_d != StLocked) begin
      w_in_run_d  = '0;
      w_out_run_d = '0;
    end
  end

  always_ff @(posedge fpga_clk_i or negedge rst_pbn_i) begin
    if (!rst_pbn_i) begin
      r_ref_sync <= '0;
      r_gen_sync <= '0;
      r_open     <= 1'b0;
      r_dir_ref  <= 1'b0;
      r_cnt      <= '0;
      r_age      <= '0;
      r_err      <= '0;
      r_valid    <= 1'b0;
      r_in_run   <= '0;
      r_out_run  <= '0;
      r_state    <= StIdle;
    end else begin
      r_ref_sync <= {r_ref_sync[1:0], ref_clk_i};
      r_gen_sync <= {r_gen_sync[1:0], gen_clk_i};
      r_open     <= w_open_d;
      r_dir_ref  <= w_dir_d;
      r_cnt      <= w_cnt_d;
      r_age      <= w_age_d;
      r_valid    <= w_pub;
      r_in_run   <= w_in_run_d;
      r_out_run  <= w_out_run_d;
      r_state    <= w_state_d;
      if (!enable_i) r_err <= '0;
      else if (w_pub) r_err <= w_pub_val;
    end
  end

  assign error_o       = r_err;
  assign error_valid_o = r_valid;
  assign locked_o      = (r_state == StLocked);
  assign lost_o        = (r_state == StLost);
  assign state_o       = r_state;

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Bench for pll_lock_monitor: a table of skew periods feeds a scoreboard of expected
// publishes, plus hand sequences for restart, timeout, reset and enable corner cases.
module tb_pll_lock_monitor;
  logic       clk = 1'b0;
  logic       rst_n, en, refc, genc;
  logic [7:0] err;
  logic       vld, lck, lst;
  logic [1:0] st;

  always #5 clk = ~clk;

  pll_lock_monitor dut (
    .fpga_clk_i   (clk),
    .rst_pbn_i    (rst_n),
    .enable_i     (en),
    .ref_clk_i    (refc),
    .gen_clk_i    (genc),
    .error_o      (err),
    .error_valid_o(vld),
    .locked_o     (lck),
    .lost_o       (lst),
    .state_o      (st)
  );

  typedef struct {int lag; int err; int st;} vec_t;
  typedef struct {int err; int st;} exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Every valid pulse must match the oldest expected publish.
  always @(posedge clk) begin
    #1;
    if (vld === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got pulse err=%0d expected none", $signed(err));
      end else begin
        mon_e = sb.pop_front();
        check("error_o", int'($signed(err)), mon_e.err);
        check("state_o", int'(st), mon_e.st);
        check("locked_o", int'(lck), int'(mon_e.st == 2));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic add_vec(input int lag, input int e, input int s, input int n);
    for (int i = 0; i < n; i++) vecs.push_back('{lag, e, s});
  endtask

  // Positive lag: gen rises lag ticks after ref; negative: gen leads.
  task automatic period(input int lag, input int exp_err, input int exp_st);
    sb.push_back('{exp_err, exp_st});
    @(negedge clk);
    if (lag >= 0) begin
      refc = 1'b1;
      cyc(lag);
      genc = 1'b1;
    end else begin
      genc = 1'b1;
      cyc(-lag);
      refc = 1'b1;
    end
    cyc(2);
    refc = 1'b0;
    genc = 1'b0;
    cyc(8);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    en    = 1'b0;
    refc  = 1'b0;
    genc  = 1'b0;

    add_vec(5, 5, 1, 3);
    add_vec(-3, -3, 1, 2);
    add_vec(0, 0, 1, 15);
    add_vec(0, 0, 2, 1);
    add_vec(10, 10, 2, 3);
    add_vec(0, 0, 2, 1);
    add_vec(10, 10, 2, 3);
    add_vec(10, 10, 1, 1);
    add_vec(1, 1, 1, 1);
    add_vec(-2, -2, 1, 1);
    add_vec(200, 127, 1, 1);
    add_vec(-200, -127, 1, 1);

    cyc(3);
    check("reset_outputs", int'({err, vld, lck, lst, st}), 0);
    rst_n = 1'b1;
    en    = 1'b1;
    cyc(3);
    check("enable_state", int'(st), 1);

    foreach (vecs[i]) period(vecs[i].lag, vecs[i].err, vecs[i].st);
    check("table_drained", sb.size(), 0);

    // Repeat ref edge restarts the window: skew measured from the second ref edge.
    sb.push_back('{3, 1});
    @(negedge clk);
    refc = 1'b1;
    cyc(2);
    refc = 1'b0;
    cyc(2);
    refc = 1'b1;
    cyc(3);
    genc = 1'b1;
    cyc(2);
    refc = 1'b0;
    genc = 1'b0;
    cyc(8);

    // Repeat ref edge coincident with gen edge closes the window.
    sb.push_back('{5, 1});
    @(negedge clk);
    refc = 1'b1;
    cyc(2);
    refc = 1'b0;
    cyc(3);
    refc = 1'b1;
    genc = 1'b1;
    cyc(2);
    refc = 1'b0;
    genc = 1'b0;
    cyc(8);
    check("corner_drained", sb.size(), 0);

    // Gen stopped: window opened by ref times out into LOST.
    @(negedge clk);
    refc = 1'b1;
    n = 0;
    for (int i = 1; i <= 2000; i++) begin
      @(posedge clk);
      #1;
      if (i == 5) refc = 1'b0;
      if (lst) begin
        n = i;
        break;
      end
    end
    check("timeout_ticks", n, 3 + 1024);
    check("lost_state", int'(st), 3);
    period(5, 5, 1);
    check("lost_cleared", int'(lst), 0);

    // Reset mid-window: outputs clear at once, no publish afterwards.
    @(negedge clk);
    refc = 1'b1;
    cyc(5);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_outputs", int'({err, vld, lck, lst, st}), 0);
    refc = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(20);
    check("after_reset_state", int'(st), 1);

    // Enable dropped mid-window: outputs clear on the next edge, no publish.
    period(7, 7, 1);
    @(negedge clk);
    refc = 1'b1;
    cyc(4);
    en = 1'b0;
    @(posedge clk);
    #1;
    check("disable_outputs", int'({err, vld, lck, lst, st}), 0);
    genc = 1'b1;
    cyc(10);
    refc = 1'b0;
    genc = 1'b0;
    cyc(5);
    en = 1'b1;
    cyc(3);
    check("reenable_state", int'(st), 1);
    period(-1, -1, 1);
    cyc(5);
    check("final_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pll_lock_monitor.md
PLL_LOCK_MONITOR -- requirements
Module: pll_lock_monitor

Interface
REQ-001 The block SHALL have parameter ERR_WIDTH, default 8, the width of the signed phase error.
REQ-002 The block SHALL have parameter LOCK_TOL, default 2, the maximum |error| in ticks that counts as in tolerance.
REQ-003 The block SHALL have parameter LOCK_COUNT, default 16, the number of consecutive in-tolerance measurements required to declare lock.
REQ-004 The block SHALL have parameter UNLOCK_COUNT, default 4, the number of consecutive out-of-tolerance measurements that cause lock to be dropped.
REQ-005 The block SHALL have parameter TIMEOUT, default 1023, the maximum number of ticks a measurement window may stay open.
REQ-006 The block SHALL have a single clock: fpga_clk_i, input, 1 bit, sampling and logic clock (258 MHz).
REQ-007 The block SHALL have rst_pbn_i, input, 1 bit, asynchronous active-low reset.
REQ-008 The block SHALL have enable_i, input, 1 bit; when high, monitoring runs.
REQ-009 The block SHALL have ref_clk_i, input, 1 bit, reference clock, asynchronous to fpga_clk_i.
REQ-010 The block SHALL have gen_clk_i, input, 1 bit, ADPLL-generated clock, asynchronous to fpga_clk_i.
REQ-011 The block SHALL have error_o, output, ERR_WIDTH bits, signed two's-complement phase error in ticks.
REQ-012 The block SHALL have error_valid_o, output, 1 bit, a one-cycle pulse when error_o is updated.
REQ-013 The block SHALL have locked_o, output, 1 bit, high in state LOCKED.
REQ-014 The block SHALL have lost_o, output, 1 bit, high in state LOST.
REQ-015 The block SHALL have state_o, output, 2 bits, encoded IDLE=0, ACQUIRE=1, LOCKED=2, LOST=3.

Function
REQ-016 Each of ref_clk_i and gen_clk_i SHALL pass through a 2-flop synchronizer followed by a rising-edge detect flop, giving a 3-cycle pin-to-pulse latency.
REQ-017 A measurement window SHALL open on the first edge pulse (ref or gen) while no window is open, with the signed counter cleared to 0.
REQ-018 While the window is open, the counter SHALL advance by +1 per cycle if it was opened by ref (gen lags) or by -1 per cycle if it was opened by gen (gen leads).
REQ-019 The counter SHALL saturate at +(2^(ERR_WIDTH-1)-1) and -(2^(ERR_WIDTH-1)-1), i.e. +/-127 at the defaults, and the window SHALL stay open while saturated.
REQ-020 The window SHALL close on the first edge pulse of the other signal.
REQ-021 On close, error_o SHALL be loaded on the next cycle together with a single-cycle error_valid_o pulse.
REQ-022 Ref and gen pulses in the same cycle with no window open SHALL publish error_o=0 with a valid pulse on the next cycle.
REQ-023 A repeat edge of the opening signal before the closing edge SHALL restart the window at 0 with the same opener and SHALL NOT publish.
REQ-024 A repeat opening edge and a closing edge in the same cycle SHALL count as a close and SHALL publish the current counter value.
REQ-025 If a window has been open for TIMEOUT+1 ticks, the window SHALL be discarded with no publish, and the state machine SHALL enter LOST.
REQ-026 State machine, IDLE->ACQUIRE: when enable_i=1.
REQ-027 State machine, ACQUIRE->LOCKED: on the publish that completes LOCK_COUNT consecutive measurements with |error| <= LOCK_TOL.
REQ-028 State machine, LOCKED->ACQUIRE: on the publish that completes UNLOCK_COUNT consecutive measurements with |error| > LOCK_TOL.
REQ-029 State machine, any state->LOST: on a timeout.
REQ-030 State machine, LOST->ACQUIRE: on the next publish.
REQ-031 State machine, any state->IDLE: when enable_i=0, synchronously, taking priority over all other transitions.
REQ-032 The in-tolerance and out-of-tolerance run counters SHALL reset on a publish of the opposite class and on entry to ACQUIRE, IDLE or LOST.
REQ-033 In IDLE: the window is closed, counters are cleared, error_o=0, and error_valid_o=0.
REQ-034 locked_o, lost_o and state_o SHALL update in the same cycle as the state register.

Reset
REQ-035 While rst_pbn_i=0, asynchronously: all synchronizer flops=0, state=IDLE, error_o=0, error_valid_o=0, locked_o=0, lost_o=0, state_o=0, all counters=0.
REQ-036 On reset release, the block SHALL start operating on the first fpga_clk_i edge; edges already present at the pins SHALL be treated as new pulses only after the 3-cycle synchronizer latency.
REQ-037 Assertion of reset mid-window SHALL discard the window with no publish.

Verification
REQ-038 Enable=1, gen rising edge 5 ticks after ref, repeated -> error_o=+5 with one valid pulse per ref period; locked_o stays 0.
REQ-039 Gen rising edge 3 ticks before ref -> error_o=-3 (8'hFD).
REQ-040 Coincident edges -> error_o=0; after 16 such periods, locked_o=1 on the 16th valid pulse and state_o=2.
REQ-041 While locked, 4 periods with lag 10 -> state_o=1 on the 4th pulse; 3 periods with lag 10 followed by 1 period with lag 0 -> stays LOCKED.
REQ-042 Gen lag of 200 ticks -> error_o=+127; gen stopped -> lost_o=1 exactly 1024 ticks after the last ref-opened window; gen restored -> state_o=1 after the next publish.
REQ-043 rst_pbn_i pulsed low mid-window, or enable_i dropped -> all outputs=0 immediately (reset) or next cycle (enable), and no valid pulse is produced.
